// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode, ALU, operand-select, LSU-size and writeback encodings
package riscv_pkg;
  localparam int ALU_OP_WIDTH = 5;
  localparam logic [4:0] LOAD_OPCODE     = 5'b00000;
  localparam logic [4:0] MISC_MEM_OPCODE = 5'b00011;
  localparam logic [4:0] OP_IMM_OPCODE   = 5'b00100;
  localparam logic [4:0] AUIPC_OPCODE    = 5'b00101;
  localparam logic [4:0] STORE_OPCODE    = 5'b01000;
  localparam logic [4:0] OP_OPCODE       = 5'b01100;
  localparam logic [4:0] LUI_OPCODE      = 5'b01101;
  localparam logic [4:0] BRANCH_OPCODE   = 5'b11000;
  localparam logic [4:0] JALR_OPCODE     = 5'b11001;
  localparam logic [4:0] JAL_OPCODE      = 5'b11011;
  localparam logic [4:0] SYSTEM_OPCODE   = 5'b11100;
  localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b01000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b00111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b01101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'b11100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'b11110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'b11101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'b11111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'b11000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'b11001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;
  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;
  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  localparam logic WB_EX_RESULT = 1'b0;
  localparam logic WB_LSU_DATA  = 1'b1;
endpackage

// File: rtl/decoder_alu_op_riscv.sv
// decoder_alu_op_riscv: ALU operation and funct-field legality for OP, OP_IMM and BRANCH
module decoder_alu_op_riscv
  import riscv_pkg::*;
(
  input  logic [4:0]              op,
  input  logic [6:0]              funct7,
  input  logic [2:0]              funct3,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    illegal
);
  logic alt;
  assign alt = funct7 == 7'h20;
  always_comb begin
    alu_op = ALU_ADD;
    illegal = 1'b0;
    case (op)
      OP_IMM_OPCODE, OP_OPCODE: begin
        case (funct3)
          3'd0: alu_op = (op == OP_OPCODE && alt) ? ALU_SUB : ALU_ADD;
          3'd1: alu_op = ALU_SLL;
          3'd2: alu_op = ALU_SLTS;
          3'd3: alu_op = ALU_SLTU;
          3'd4: alu_op = ALU_XOR;
          3'd5: alu_op = alt ? ALU_SRA : ALU_SRL;
          3'd6: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        // OP_IMM funct7 is immediate data except for the shift encodings
        illegal = (op == OP_OPCODE)
          ? !(funct7 == 7'h00 || (alt && (funct3 == 3'd0 || funct3 == 3'd5)))
          : (funct3 == 3'd1 && funct7 != 7'h00) || (funct3 == 3'd5 && funct7 != 7'h00 && !alt);
      end
      BRANCH_OPCODE: begin
        case (funct3)
          3'd0: alu_op = ALU_EQ;
          3'd1: alu_op = ALU_NE;
          3'd4: alu_op = ALU_LTS;
          3'd5: alu_op = ALU_GES;
          3'd6: alu_op = ALU_LTU;
          3'd7: alu_op = ALU_GEU;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decoder_riscv.sv
// decoder_riscv: combinational RV32I main decoder with sticky illegal-instruction flag.
// Define DECODER_STRICT_SYSTEM_EN to restrict SYSTEM to ECALL/EBREAK and MISC_MEM to funct3=0.
module decoder_riscv
  import riscv_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [31:0]             fetched_instr_i,
  output logic [1:0]              ex_op_a_sel_o,
  output logic [2:0]              ex_op_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic                    gpr_we_a_o,
  output logic                    wb_src_sel_o,
  output logic                    illegal_instr_o,
  output logic                    branch_o,
  output logic                    jal_o,
  output logic                    jalr_o,
  output logic                    illegal_seen_o
);
  logic [4:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] a;
  logic [2:0] b, size;
  logic [ALU_OP_WIDTH-1:0] alu, sub_alu;
  logic req, we, gpr, wb, br, j, jr, bad, sub_bad, ill;
  logic unused_bits;
  assign op = fetched_instr_i[6:2];
  assign funct3 = fetched_instr_i[14:12];
  assign funct7 = fetched_instr_i[31:25];
  assign unused_bits = ^{fetched_instr_i[24:15], fetched_instr_i[11:7]};
  decoder_alu_op_riscv u_alu_op (
    .op(op),
    .funct7(funct7),
    .funct3(funct3),
    .alu_op(sub_alu),
    .illegal(sub_bad)
  );
  always_comb begin
    a = OP_A_RS1;
    b = OP_B_IMM_I;
    alu = ALU_ADD;
    size = LDST_W;
    wb = WB_EX_RESULT;
    req = 1'b0;
    we = 1'b0;
    gpr = 1'b0;
    br = 1'b0;
    j = 1'b0;
    jr = 1'b0;
    bad = 1'b0;
    case (op)
      LOAD_OPCODE: begin
        req = 1'b1;
        size = funct3;
        wb = WB_LSU_DATA;
        gpr = 1'b1;
        bad = funct3 == 3'd3 || funct3[2:1] == 2'b11;
      end
      STORE_OPCODE: begin
        b = OP_B_IMM_S;
        req = 1'b1;
        we = 1'b1;
        size = funct3;
        bad = funct3 >= 3'd3;
      end
      OP_IMM_OPCODE: begin
        alu = sub_alu;
        gpr = 1'b1;
        bad = sub_bad;
      end
      OP_OPCODE: begin
        b = OP_B_RS2;
        alu = sub_alu;
        gpr = 1'b1;
        bad = sub_bad;
      end
      LUI_OPCODE: begin
        a = OP_A_ZERO;
        b = OP_B_IMM_U;
        gpr = 1'b1;
      end
      AUIPC_OPCODE: begin
        a = OP_A_CURR_PC;
        b = OP_B_IMM_U;
        gpr = 1'b1;
      end
      BRANCH_OPCODE: begin
        b = OP_B_RS2;
        alu = sub_alu;
        br = 1'b1;
        bad = sub_bad;
      end
      JAL_OPCODE: begin
        a = OP_A_CURR_PC;
        b = OP_B_INCR;
        gpr = 1'b1;
        j = 1'b1;
      end
      JALR_OPCODE: begin
        a = OP_A_CURR_PC;
        b = OP_B_INCR;
        gpr = 1'b1;
        jr = 1'b1;
        bad = funct3 != 3'd0;
      end
`ifdef DECODER_STRICT_SYSTEM_EN
      MISC_MEM_OPCODE: bad = funct3 != 3'd0;
      SYSTEM_OPCODE: bad = fetched_instr_i != ECALL_INSTR && fetched_instr_i != EBREAK_INSTR;
`else
      MISC_MEM_OPCODE, SYSTEM_OPCODE: bad = 1'b0;
`endif
      default: bad = 1'b1;
    endcase
  end
  // an illegal word drops every side effect and reverts selects to their defaults
  assign ill = bad || fetched_instr_i[1:0] != 2'b11;
  assign illegal_instr_o = ill;
  assign ex_op_a_sel_o = ill ? OP_A_RS1 : a;
  assign ex_op_b_sel_o = ill ? OP_B_IMM_I : b;
  assign alu_op_o = ill ? ALU_ADD : alu;
  assign mem_size_o = ill ? LDST_W : size;
  assign wb_src_sel_o = ill ? WB_EX_RESULT : wb;
  assign mem_req_o = req && !ill;
  assign mem_we_o = we && !ill;
  assign gpr_we_a_o = gpr && !ill;
  assign branch_o = br && !ill;
  assign jal_o = j && !ill;
  assign jalr_o = jr && !ill;
  always_ff @(posedge clk_i)
    if (!rstn_i) illegal_seen_o <= 1'b0;
    else if (ill) illegal_seen_o <= 1'b1;
endmodule

// File: tb/tb_decoder_riscv.sv
// tb_decoder_riscv: directed vector table, sticky-flag sequences and randomized
// decode checks against a behavioural model of the RV32I decode rules.
module tb_decoder_riscv;
  import riscv_pkg::*;
  typedef struct packed {
    logic [1:0] a;
    logic [2:0] b;
    logic [4:0] alu;
    logic req, we;
    logic [2:0] size;
    logic gpr, wb, ill, br, j, jr;
  } dec_t;
  typedef struct {
    string name;
    logic [31:0] instr;
    dec_t exp;
  } vec_t;
  logic clk = 0, rstn = 0;
  logic [31:0] instr = 32'h0;
  logic [1:0] a_sel;
  logic [2:0] b_sel, size;
  logic [4:0] alu;
  logic req, we, gpr, wb, ill, br, j, jr, seen;
  int checks = 0, errors = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  decoder_riscv dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .fetched_instr_i(instr),
    .ex_op_a_sel_o(a_sel),
    .ex_op_b_sel_o(b_sel),
    .alu_op_o(alu),
    .mem_req_o(req),
    .mem_we_o(we),
    .mem_size_o(size),
    .gpr_we_a_o(gpr),
    .wb_src_sel_o(wb),
    .illegal_instr_o(ill),
    .branch_o(br),
    .jal_o(j),
    .jalr_o(jr),
    .illegal_seen_o(seen)
  );
  function automatic dec_t mk(int a, int b, int al, int rq, int w, int sz, int g, int s, int il, int bb, int jj, int jjr);
    mk = {a[1:0], b[2:0], al[4:0], rq[0], w[0], sz[2:0], g[0], s[0], il[0], bb[0], jj[0], jjr[0]};
  endfunction
  function automatic dec_t model(logic [31:0] w);
    logic [4:0] op = w[6:2];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [4:0] arith [8] = '{ALU_ADD, ALU_SLL, ALU_SLTS, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [4:0] cmp [8] = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LTS, ALU_GES, ALU_LTU, ALU_GEU};
    dec_t d = mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    bit ok = w[1:0] == 2'b11;
    case (op)
      5'b00000: begin ok &= f3 inside {0, 1, 2, 4, 5}; d.req = 1; d.size = f3; d.wb = 1; d.gpr = 1; end
      5'b01000: begin ok &= f3 < 3; d.b = 3; d.req = 1; d.we = 1; d.size = f3; end
      5'b00100: begin
        d.gpr = 1;
        d.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : arith[f3];
        if (f3 == 1) ok &= f7 == 0;
        if (f3 == 5) ok &= f7 inside {7'h00, 7'h20};
      end
      5'b01100: begin
        d.b = 0; d.gpr = 1;
        d.alu = f7 != 7'h20 ? arith[f3] : (f3 == 0 ? ALU_SUB : ALU_SRA);
        ok &= f7 == 0 || (f7 == 7'h20 && f3 inside {0, 5});
      end
      5'b01101: begin d.a = 2; d.b = 2; d.gpr = 1; end
      5'b00101: begin d.a = 1; d.b = 2; d.gpr = 1; end
      5'b11000: begin d.b = 0; d.br = 1; d.alu = cmp[f3]; ok &= !(f3 inside {2, 3}); end
      5'b11011: begin d.a = 1; d.b = 4; d.gpr = 1; d.j = 1; end
      5'b11001: begin d.a = 1; d.b = 4; d.gpr = 1; d.jr = 1; ok &= f3 == 0; end
`ifdef DECODER_STRICT_SYSTEM_EN
      5'b00011: ok &= f3 == 0;
      5'b11100: ok &= w == 32'h0000_0073 || w == 32'h0010_0073;
`else
      5'b00011, 5'b11100: ;
`endif
      default: ok = 0;
    endcase
    if (!ok) d = mk(0, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    return d;
  endfunction
  task automatic chk(string name, dec_t exp);
    dec_t act;
    act = {a_sel, b_sel, alu, req, we, size, gpr, wb, ill, br, j, jr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s instr=%h got=%h expected=%h", name, instr, act, exp);
    end
  endtask
  task automatic chk_seen(string name, logic exp);
    checks++;
    if (seen !== exp) begin
      errors++;
      $display("FAIL %s illegal_seen got=%b expected=%b", name, seen, exp);
    end
  endtask
  initial begin
    dec_t ilx;
    ilx = mk(0, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    vecs.push_back('{"add",      32'h00A5_0533, mk(0, 0, ALU_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"sub",      32'h40A5_0533, mk(0, 0, ALU_SUB, 0, 0, 2, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"op_f7_01", 32'h02A5_0533, ilx});
    vecs.push_back('{"lw",       32'h0045_2283, mk(0, 1, ALU_ADD, 1, 0, 2, 1, 1, 0, 0, 0, 0)});
    vecs.push_back('{"load_f3_3",32'h0045_3283, ilx});
    vecs.push_back('{"sw",       32'h00A5_2223, mk(0, 3, ALU_ADD, 1, 1, 2, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"store_f3_4",32'h00A5_4223, ilx});
    vecs.push_back('{"beq",      32'h00A5_0463, mk(0, 0, ALU_EQ, 0, 0, 2, 0, 0, 0, 1, 0, 0)});
    vecs.push_back('{"br_f3_2",  32'h00A5_2463, ilx});
    vecs.push_back('{"bltu",     32'h00A5_6463, mk(0, 0, ALU_LTU, 0, 0, 2, 0, 0, 0, 1, 0, 0)});
    vecs.push_back('{"jal",      32'h0080_00EF, mk(1, 4, ALU_ADD, 0, 0, 2, 1, 0, 0, 0, 1, 0)});
    vecs.push_back('{"jalr",     32'h0000_80E7, mk(1, 4, ALU_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 1)});
    vecs.push_back('{"jalr_f3_1",32'h0000_90E7, ilx});
    vecs.push_back('{"lui",      32'h1234_52B7, mk(2, 2, ALU_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"auipc",    32'h1234_5297, mk(1, 2, ALU_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"srai",     32'h4052_D293, mk(0, 1, ALU_SRA, 0, 0, 2, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"lbu",      32'h0045_4283, mk(0, 1, ALU_ADD, 1, 0, 4, 1, 1, 0, 0, 0, 0)});
    vecs.push_back('{"fence",    32'h0000_000F, mk(0, 1, ALU_ADD, 0, 0, 2, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"ecall",    32'h0000_0073, mk(0, 1, ALU_ADD, 0, 0, 2, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"zero_word",32'h0000_0000, ilx});
    vecs.push_back('{"bad_op",   32'h0000_007F, ilx});
    // reset holds through an illegal word, and decode is unaffected by reset
    rstn = 0;
    instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_seen("reset_wins", 1'b0);
    chk("decode_in_reset", ilx);
    @(negedge clk);
    instr = 32'h00A5_0533;
    rstn = 1;
    @(posedge clk);
    #1;
    chk_seen("legal_holds_0", 1'b0);
    foreach (vecs[i]) begin
      @(negedge clk);
      instr = vecs[i].instr;
      #1;
      chk(vecs[i].name, vecs[i].exp);
    end
    @(negedge clk);
    rstn = 0;
    instr = 32'h00A5_0533;
    @(posedge clk);
    #1;
    chk_seen("reset_clears", 1'b0);
    @(negedge clk);
    rstn = 1;
    instr = 32'h0;
    @(posedge clk);
    #1;
    chk_seen("sets_on_illegal", 1'b1);
    @(negedge clk);
    instr = 32'h00A5_0533;
    repeat (3) @(posedge clk);
    #1;
    chk_seen("sticky", 1'b1);
    @(negedge clk);
    rstn = 0;
    @(posedge clk);
    #1;
    chk_seen("reset_one_edge", 1'b0);
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 4; k++)
      for (int op = 0; op < 32; op++) begin
        logic [31:0] w;
        w = $urandom;
        w[6:2] = op[4:0];
        w[1:0] = (k == 3) ? 2'($urandom) : 2'b11;
        if (k == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        instr = w;
        #1;
        chk($sformatf("sweep_op%0d", op), model(w));
        #4;
      end
    for (int k = 0; k < 400; k++) begin
      instr = $urandom;
      #1;
      chk("random", model(instr));
      #4;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
